// File: rtl/button_debouncer_pkg.sv
// Shared types and defaults for the button debouncer: FSM encoding,
// default stable-cycle count and the counter-width helper.
package button_debouncer_pkg;

    typedef enum logic [1:0] {
        LOW_STABLE  = 2'd0,
        LOW_COUNT   = 2'd1,
        HIGH_STABLE = 2'd2,
        HIGH_COUNT  = 2'd3
    } deb_state_e;

    localparam int DEFAULT_STABLE_CYCLES = 1000000;

    // Smallest width w with 2^w > max_val, so the counter can hold max_val.
    function automatic int cnt_width(input int max_val);
        int w;
        w = 1;
        for (int i = 1; i < 31; i++) begin
            if ((1 << w) <= max_val) w = i + 1;
        end
        return w;
    endfunction

    localparam int DEFAULT_CNT_W = cnt_width(DEFAULT_STABLE_CYCLES);

endpackage

// File: rtl/button_debouncer_if.sv
// Button-side signal bundle: raw input toward the debouncer, clean level
// and strobes back toward the consuming logic.
interface button_debouncer_if;
    logic btn_in;
    logic btn_level;
    logic btn_press;
    logic btn_release;

    modport master (output btn_in, input btn_level, input btn_press, input btn_release);
    modport slave  (input btn_in, output btn_level, output btn_press, output btn_release);
endinterface

// File: rtl/button_debouncer_sync_2ff.sv
// Two-flop synchronizer for a single asynchronous input; reusable for any
// raw input entering the clk domain.
module sync_2ff (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic s1_q, s1_d;
    logic s2_q, s2_d;

    always_comb begin
        s1_d = d;
        s2_d = s1_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_q <= 1'b0;
            s2_q <= 1'b0;
        end else begin
            s1_q <= s1_d;
            s2_q <= s2_d;
        end
    end

    assign q = s2_q;

endmodule

// File: rtl/button_debouncer.sv
// Counter-based debouncer behind a 2-flop synchronizer: clean level plus
// press strobe; release strobe built only with DEBOUNCE_RELEASE_PULSE_EN.
module button_debouncer
    import button_debouncer_pkg::*;
#(
    parameter int STABLE_CYCLES = DEFAULT_STABLE_CYCLES,
    parameter int CNT_W         = DEFAULT_CNT_W
) (
    input  logic                 clk,
    input  logic                 rst,
    button_debouncer_if.slave    bus
);

    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STABLE_CYCLES);
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    logic             btn_sync;
    deb_state_e       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             level_q, level_d;
    logic             press_q, press_d;
`ifdef DEBOUNCE_RELEASE_PULSE_EN
    logic             release_q, release_d;
`endif

    sync_2ff u_sync (
        .clk (clk),
        .rst (rst),
        .d   (bus.btn_in),
        .q   (btn_sync)
    );

    // Counter restarts on every bounce and every flip, so it never exceeds CNT_MAX.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        level_d = level_q;
        press_d = 1'b0;
`ifdef DEBOUNCE_RELEASE_PULSE_EN
        release_d = 1'b0;
`endif
        case (state_q)
            LOW_STABLE: begin
                if (btn_sync) begin
                    state_d = LOW_COUNT;
                    cnt_d   = CNT_ONE;
                end
            end
            LOW_COUNT: begin
                if (!btn_sync) begin
                    state_d = LOW_STABLE;
                    cnt_d   = '0;
                end else if (cnt_q == CNT_MAX) begin
                    state_d = HIGH_STABLE;
                    cnt_d   = '0;
                    level_d = 1'b1;
                    press_d = 1'b1;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            HIGH_STABLE: begin
                if (!btn_sync) begin
                    state_d = HIGH_COUNT;
                    cnt_d   = CNT_ONE;
                end
            end
            HIGH_COUNT: begin
                if (btn_sync) begin
                    state_d = HIGH_STABLE;
                    cnt_d   = '0;
                end else if (cnt_q == CNT_MAX) begin
                    state_d = LOW_STABLE;
                    cnt_d   = '0;
                    level_d = 1'b0;
`ifdef DEBOUNCE_RELEASE_PULSE_EN
                    release_d = 1'b1;
`endif
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            default: begin
                state_d = LOW_STABLE;
                cnt_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= LOW_STABLE;
            cnt_q   <= '0;
            level_q <= 1'b0;
            press_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            level_q <= level_d;
            press_q <= press_d;
        end
    end

`ifdef DEBOUNCE_RELEASE_PULSE_EN
    always_ff @(posedge clk) begin
        if (rst) release_q <= 1'b0;
        else     release_q <= release_d;
    end
    assign bus.btn_release = release_q;
`else
    assign bus.btn_release = 1'b0;
`endif

    assign bus.btn_level = level_q;
    assign bus.btn_press = press_q;

endmodule
